// File: rtl/record_coupler.sv
// Packs a stream of records into two-record pair-words and queues them in a
// first-word-fall-through buffer; a zero record closes the current pair early.
module record_coupler #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [DATA_WIDTH-1:0]     i_data,
    input  logic                      i_write,
    output logic                      o_full,
    output logic [2*DATA_WIDTH-1:0]   o_data,
    output logic                      o_empty,
    input  logic                      i_read,
    output logic [$clog2(DEPTH):0]    o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        LOW,
        HAVE_LOW
    } state_t;

    state_t                    state;
    state_t                    next_state;
    logic [DATA_WIDTH-1:0]     staged;
    logic [DATA_WIDTH-1:0]     next_staged;
    logic [2*DATA_WIDTH-1:0]   push_word;
    logic                      accept;
    logic                      push;
    logic                      pop;

    logic [2*DATA_WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          count;

    assign o_count = count;
    assign o_full  = (count == CNT_W'(DEPTH));
    assign o_empty = (count == '0);
    assign o_data  = o_empty ? '0 : mem[rd_ptr];

    assign accept = i_write && !o_full;
    assign pop    = i_read && !o_empty;

    // A terminator flushes whatever is staged (or nothing) as a complete pair.
    always_comb begin
        next_state  = state;
        next_staged = staged;
        push        = 1'b0;
        push_word   = '0;
        if (accept) begin
            if (i_data == '0) begin
                push       = 1'b1;
                push_word  = {{DATA_WIDTH{1'b0}}, (state == HAVE_LOW) ? staged : {DATA_WIDTH{1'b0}}};
                next_state = LOW;
            end else if (state == HAVE_LOW) begin
                push       = 1'b1;
                push_word  = {i_data, staged};
                next_state = LOW;
            end else begin
                next_staged = i_data;
                next_state  = HAVE_LOW;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= LOW;
            staged <= '0;
        end else begin
            state  <= next_state;
            staged <= next_staged;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage is left unreset; the empty mask keeps stale words off o_data.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= push_word;
        end
    end

endmodule

// File: tb/tb_record_coupler.sv
// Directed and random checks of record_coupler against a queue-based pairing model.
module tb_record_coupler;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic            i_clk;
    logic            i_rst_n;
    logic [DW-1:0]   i_data;
    logic            i_write;
    logic            o_full;
    logic [2*DW-1:0] o_data;
    logic            o_empty;
    logic            i_read;
    logic [2:0]      o_count;

    int tests_run;
    int tests_failed;

    logic [2*DW-1:0] exp_q[$];
    logic            m_have;
    logic [DW-1:0]   m_staged;
    int              push_total;

    record_coupler #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (i_data),
        .i_write (i_write),
        .o_full  (o_full),
        .o_data  (o_data),
        .o_empty (o_empty),
        .i_read  (i_read),
        .o_count (o_count)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check_value(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Compares every output against the model's view of the buffer.
    task automatic check_output(input string tag);
        logic [63:0] exp_data;
        exp_data = (exp_q.size() == 0) ? 64'h0 : exp_q[0];
        check_value({tag, "_count"}, 64'(o_count), 64'(exp_q.size()));
        check_value({tag, "_empty"}, 64'(o_empty), 64'(exp_q.size() == 0));
        check_value({tag, "_full"},  64'(o_full),  64'(exp_q.size() == DEPTH));
        check_value({tag, "_data"},  o_data,       exp_data);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_have   = 1'b0;
        m_staged = '0;
    endtask

    task automatic apply_stimulus(input logic [DW-1:0] d, input logic w, input logic r, input string tag);
        bit accept;
        bit popping;
        check_output(tag);
        i_data  = d;
        i_write = w;
        i_read  = r;
        accept  = w && (exp_q.size() != DEPTH);
        popping = r && (exp_q.size() != 0);
        if (popping) begin
            void'(exp_q.pop_front());
        end
        if (accept) begin
            if (d == '0) begin
                exp_q.push_back({32'h0, m_have ? m_staged : 32'h0});
                m_have = 1'b0;
                push_total++;
            end else if (m_have) begin
                exp_q.push_back({d, m_staged});
                m_have = 1'b0;
                push_total++;
            end else begin
                m_staged = d;
                m_have   = 1'b1;
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 2 * DEPTH && exp_q.size() != 0; i++) begin
            apply_stimulus('0, 1'b0, 1'b1, tag);
        end
        check_value({tag, "_drained"}, 64'(o_empty), 64'h1);
    endtask

    initial begin
        logic [DW-1:0] rnd_data;
        tests_run    = 0;
        tests_failed = 0;
        push_total   = 0;
        i_rst_n      = 1'b0;
        i_data       = '0;
        i_write      = 1'b0;
        i_read       = 1'b0;
        model_reset();
        repeat (3) @(posedge i_clk);
        #1;
        check_output("reset");
        #2 i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // Two nonzero records form one pair, visible one cycle after the push.
        apply_stimulus(32'd5, 1'b1, 1'b0, "w5");
        apply_stimulus(32'd7, 1'b1, 1'b0, "w7");
        check_value("pair57_data", o_data, 64'h00000007_00000005);
        check_value("pair57_count", 64'(o_count), 64'd1);
        check_value("pair57_empty", 64'(o_empty), 64'h0);
        drain("drain57");

        // Terminator after a staged record, then a lone terminator from LOW.
        apply_stimulus(32'd3, 1'b1, 1'b0, "w3");
        apply_stimulus(32'd0, 1'b1, 1'b0, "w3term");
        check_value("pair30_data", o_data, 64'h00000000_00000003);
        apply_stimulus(32'd0, 1'b1, 1'b0, "wterm_low");
        check_value("twoterm_count", 64'(o_count), 64'd2);
        apply_stimulus('0, 1'b0, 1'b1, "pop30");
        check_value("zero_pair_data", o_data, 64'h0);
        drain("drain30");

        // Fill to full, then a write that must be ignored.
        for (int i = 1; i <= 8; i++) begin
            apply_stimulus(DW'(i), 1'b1, 1'b0, "fill");
        end
        check_value("full_flag", 64'(o_full), 64'h1);
        check_value("full_count", 64'(o_count), 64'd4);
        apply_stimulus(32'd9, 1'b1, 1'b0, "w9_full");
        check_value("full_hold_count", 64'(o_count), 64'd4);
        check_value("full_head", o_data, 64'h00000002_00000001);
        drain("drain_full");
        apply_stimulus(32'd10, 1'b1, 1'b0, "w10");
        apply_stimulus(32'd11, 1'b1, 1'b0, "w11");
        check_value("after_full_pair", o_data, 64'h0000000B_0000000A);
        drain("drain_after_full");

        // Simultaneous push and pop at an occupancy of two.
        apply_stimulus(32'd1, 1'b1, 1'b0, "s1");
        apply_stimulus(32'd2, 1'b1, 1'b0, "s2");
        apply_stimulus(32'd3, 1'b1, 1'b0, "s3");
        apply_stimulus(32'd4, 1'b1, 1'b0, "s4");
        apply_stimulus(32'd5, 1'b1, 1'b0, "s5");
        apply_stimulus(32'd6, 1'b1, 1'b1, "s6pop");
        check_value("pushpop_count", 64'(o_count), 64'd2);
        check_value("pushpop_head", o_data, 64'h00000004_00000003);
        drain("drain_pushpop");

        // Asynchronous reset mid-cycle discards the staged record.
        apply_stimulus(32'd9, 1'b1, 1'b0, "stage9");
        apply_stimulus('0, 1'b0, 1'b0, "idle9");
        #2 i_rst_n = 1'b0;
        model_reset();
        #1;
        check_output("async_rst");
        #2 i_rst_n = 1'b1;
        apply_stimulus(32'd4, 1'b1, 1'b0, "w4");
        apply_stimulus(32'd6, 1'b1, 1'b0, "w6");
        check_value("post_rst_pair", o_data, 64'h00000006_00000004);
        check_value("post_rst_count", 64'(o_count), 64'd1);
        drain("drain_rst");

        // Long random stream with terminators and random pops.
        push_total = 0;
        for (int i = 0; i < 600; i++) begin
            rnd_data = ($urandom_range(0, 4) == 0) ? '0 : $urandom();
            apply_stimulus(rnd_data, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, "rand");
        end
        check_value("rand_wraps", 64'(push_total > 3 * DEPTH), 64'h1);
        drain("drain_rand");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/record_coupler.md
RECORD_COUPLER -- requirements
Module: record_coupler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, record width in bits; a record value of zero is the end-of-run terminator.
REQ-002 SHALL have parameter DEPTH, default 8, output buffer depth in pair-words; power of two, at least 2.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_data  input  DATA_WIDTH  record from the upstream merger output.
REQ-006 SHALL have port i_write  input  1  i_data valid this cycle (merger not stalled).
REQ-007 SHALL have port o_full  output  1  backpressure; drives the merger's output-FIFO-full input.
REQ-008 SHALL have port o_data  output  2*DATA_WIDTH  head pair-word; bits [DATA_WIDTH-1:0] hold the earlier record.
REQ-009 SHALL have port o_empty  output  1  buffer holds no pair-word.
REQ-010 SHALL have port i_read  input  1  downstream pop of the head pair-word.
REQ-011 SHALL have port o_count  output  log2(DEPTH)+1  buffer occupancy in pair-words.

Function
REQ-012 SHALL pack consecutive records into pair-words using a two-state FSM: LOW (no record staged) and HAVE_LOW (one record held in the staging register).
REQ-013 SHALL accept a write only when i_write=1 and o_full=0; a write while o_full=1 SHALL be ignored, with no change to FSM, staging register or buffer.
REQ-014 In LOW, an accepted nonzero record SHALL be loaded into the staging register, and the FSM SHALL move to HAVE_LOW; no push occurs.
REQ-015 In HAVE_LOW, an accepted nonzero record SHALL push {new, staged} into the buffer, and the FSM SHALL move to LOW.
REQ-016 In HAVE_LOW, an accepted terminator SHALL push {0, staged}, and the FSM SHALL move to LOW.
REQ-017 In LOW, an accepted terminator SHALL push {0, 0}; the FSM SHALL stay in LOW.
REQ-018 SHALL make a pushed word visible on o_data, and SHALL deassert o_empty, on the cycle after the push edge (first-word-fall-through, 1-cycle latency).
REQ-019 o_data SHALL equal the buffer head when o_empty=0, and SHALL be all-zero when o_empty=1.
REQ-020 SHALL ignore i_read when o_empty=1; otherwise i_read SHALL advance the read pointer at the edge.
REQ-021 A simultaneous push and pop SHALL leave o_count unchanged and advance both pointers.
REQ-022 o_full SHALL be combinational and equal (o_count == DEPTH); o_empty SHALL equal (o_count == 0).
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; o_count SHALL never exceed DEPTH and never underflow.
REQ-024 SHALL preserve record order across pair-words and within each pair-word; no record SHALL be dropped or duplicated.

Reset
REQ-025 When i_rst_n=0, the block SHALL asynchronously force: FSM=LOW, staging register=0, pointers=0, o_count=0, o_empty=1, o_full=0, o_data=0.
REQ-026 Reset asserted mid-run SHALL discard the staged record and all buffered words; the first accepted record after release SHALL be treated as a LOW-state record.
REQ-027 Buffer storage need not be reset; REQ-019 masking SHALL guarantee o_data=0 while empty.

Verification (DATA_WIDTH=32, DEPTH=4)
REQ-028 Write 5,7 on consecutive cycles -> one cycle after the second write: o_data=0x00000007_00000005, o_count=1, o_empty=0.
REQ-029 Write 3,0 -> o_data=0x00000000_00000003; then write 0 from LOW -> second word 0x0 and o_count=2.
REQ-030 Write eight nonzero records 1..8 with i_read=0 -> o_count=4, o_full=1; a ninth write of 9 -> ignored, FSM stays LOW, o_count stays 4.
REQ-031 At o_count=2, push and pop in the same cycle -> o_count stays 2, and the head advances to the next pair in order.
REQ-032 Write 9 (staged), assert i_rst_n=0 asynchronously mid-cycle, release, then write 4,6 -> the only word is 0x00000006_00000004; record 9 is lost.
REQ-033 Long random stream with random i_read and terminators, compared against a reference pairing model -> exact match, including wrap of both pointers at least 3 times.
